// File: rtl/buf_pipe.sv
// buf_pipe: WIDTH-bit buffer with a runtime-selectable pipeline depth of
// 0..MAX_DEPTH register stages. A valid bit travels alongside the data.
// Depth 0 is a combinational pass-through. Changing the depth clears all
// in-flight valid bits and raises busy for "new depth" cycles.
//
// Optional feature macro: BUF_PIPE_HOLD_EN
//   defined   - out holds the last value presented with out_valid = 1
//               while out_valid is low (extra WIDTH-bit hold register).
//   undefined - out is the raw selected stage (or in) value.
module buf_pipe #(
  parameter int WIDTH     = 1,
  parameter int MAX_DEPTH = 4,
  parameter int DEPTH_W   = 3
) (
  input  logic               CK,
  input  logic               RSTN,
  input  logic [WIDTH-1:0]   in,
  input  logic               in_valid,
  input  logic [DEPTH_W-1:0] cfg_depth,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  output logic               busy
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);

  state_t             state_reg, state_next;
  logic [DEPTH_W-1:0] dq_reg, dq_next;
  logic [DEPTH_W-1:0] cnt_reg, cnt_next;
  logic [DEPTH_W-1:0] cd;
  logic               depth_change;

  logic [WIDTH-1:0]   stage_data_reg [1:MAX_DEPTH];
  logic [WIDTH-1:0]   stage_data_in  [1:MAX_DEPTH];
  logic [MAX_DEPTH:1] stage_valid_reg;
  logic [MAX_DEPTH:1] stage_valid_in;

  logic [WIDTH-1:0]   sel_data;
  logic               sel_valid;
  logic               valid_gated;

  // Requested depth clamped to the number of physical stages
  assign cd           = (cfg_depth > MAX_D) ? MAX_D : cfg_depth;
  assign depth_change = (cd != dq_reg);

  // Stage inputs: stage 1 takes the block input, later stages chain
  generate
    for (genvar gi = 1; gi <= MAX_DEPTH; gi++) begin : g_stage_in
      if (gi == 1) begin : g_first
        assign stage_data_in[gi]  = in;
        assign stage_valid_in[gi] = in_valid;
      end else begin : g_chain
        assign stage_data_in[gi]  = stage_data_reg[gi-1];
        assign stage_valid_in[gi] = stage_valid_reg[gi-1];
      end
    end
  endgenerate

  // Data shift register: shifts every edge, never cleared by a depth change
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      for (int k = 1; k <= MAX_DEPTH; k++) begin
        stage_data_reg[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= MAX_DEPTH; k++) begin
        stage_data_reg[k] <= stage_data_in[k];
      end
    end
  end

  // Valid shift register: a depth change drops everything in flight,
  // including the in_valid sampled at that same edge
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      stage_valid_reg <= '0;
    end else if (depth_change) begin
      stage_valid_reg <= '0;
    end else begin
      stage_valid_reg <= stage_valid_in;
    end
  end

  // FSM state, registered depth and flush counter
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg <= RUN;
      dq_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      dq_reg    <= dq_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: a depth change (re)starts the flush, otherwise the
  // flush counter runs down and returns to RUN after its last busy cycle
  always_comb begin
    state_next = state_reg;
    dq_next    = dq_reg;
    cnt_next   = cnt_reg;
    if (depth_change) begin
      dq_next    = cd;
      cnt_next   = cd;
      state_next = (cd != '0) ? FLUSH : RUN;
    end else begin
      case (state_reg)
        FLUSH: begin
          if (cnt_reg <= DEPTH_W'(1)) begin
            cnt_next   = '0;
            state_next = RUN;
          end else begin
            cnt_next = cnt_reg - DEPTH_W'(1);
          end
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  // Output tap: depth 0 passes the input through, otherwise stage dq
  always_comb begin
    sel_data  = in;
    sel_valid = in_valid;
    for (int k = 1; k <= MAX_DEPTH; k++) begin
      if (dq_reg == DEPTH_W'(k)) begin
        sel_data  = stage_data_reg[k];
        sel_valid = stage_valid_reg[k];
      end
    end
  end

  assign valid_gated = sel_valid && (state_reg == RUN);

  // Qualifiers are forced low while reset is held, even at depth 0
  assign out_valid = RSTN && valid_gated;
  assign busy      = RSTN && (state_reg == FLUSH);

`ifdef BUF_PIPE_HOLD_EN
  logic [WIDTH-1:0] hold_reg;

  // Capture every word presented as valid so it can be shown while idle
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      hold_reg <= '0;
    end else if (valid_gated) begin
      hold_reg <= sel_data;
    end
  end

  assign out = !RSTN ? '0 : (valid_gated ? sel_data : hold_reg);
`else
  assign out = RSTN ? sel_data : '0;
`endif

endmodule

// File: tb/tb_buf_pipe.sv
// Directed bench for buf_pipe (WIDTH=8, MAX_DEPTH=4). Every step drives one
// set of inputs after a rising edge and observes at the following falling
// edge. Expected words go into a scoreboard queue tagged with the step at
// which they must appear; a small model tracks depth and flush length.
module tb_buf_pipe;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       in_valid;
  logic [2:0] cfg_depth;
  logic [7:0] dout;
  logic       out_valid;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t       q[$];
  logic [2:0] m_dq;
  int         m_cnt;
  logic [7:0] m_last;

  buf_pipe #(
    .WIDTH(8),
    .MAX_DEPTH(4),
    .DEPTH_W(3)
  ) dut (
    .CK(clk),
    .RSTN(rst_n),
    .in(din),
    .in_valid(in_valid),
    .cfg_depth(cfg_depth),
    .out(dout),
    .out_valid(out_valid),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dq   = 3'd0;
    m_cnt  = 0;
    m_last = 8'h00;
    q.delete();
  endtask

  // One cycle: drive, predict, observe, then advance the model to the next edge
  task automatic step(input logic [2:0] depth, input logic vld, input logic [7:0] data);
    exp_t       e;
    logic [2:0] cd;
    logic       chg;
    logic       exp_v;
    @(posedge clk);
    #1;
    cfg_depth = depth;
    in_valid  = vld;
    din       = data;
    cd  = (depth > 3'd4) ? 3'd4 : depth;
    chg = (cd != m_dq);
    // at depth 0 the word is already visible this cycle; otherwise a depth
    // change at the coming edge drops it
    if (vld && ((m_dq == 3'd0) || !chg)) begin
      e.data = data;
      e.at   = cyc + int'(m_dq);
      q.push_back(e);
    end
    @(negedge clk);
    check("busy", busy, (m_cnt != 0));
    exp_v = (q.size() > 0) && (q[0].at == cyc);
    check("out_valid", out_valid, exp_v);
    if (exp_v) begin
      e = q.pop_front();
      check("out_data", dout, e.data);
      $display("txn step=%0d depth=%0d out=%02h out_valid=%0b busy=%0b", cyc, m_dq, dout, out_valid, busy);
      m_last = e.data;
    end else begin
`ifdef BUF_PIPE_HOLD_EN
      check("out_hold", dout, m_last);
`endif
    end
    if (chg) begin
      m_dq  = cd;
      m_cnt = int'(cd);
      q.delete();
    end else if (m_cnt != 0) begin
      m_cnt--;
    end
    cyc++;
  endtask

  // Asynchronous reset pulse in the middle of a cycle
  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_out", dout, 8'h00);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    cfg_depth = 3'd0;
    in_valid  = 1'b0;
    din       = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    // Reset with depth 0 and a valid word on the input: outputs stay low
    rst_n     = 1'b0;
    cfg_depth = 3'd0;
    din       = 8'h01;
    in_valid  = 1'b1;
    model_reset();
    #12;
    check("por_out", dout, 8'h00);
    check("por_out_valid", out_valid, 1'b0);
    check("por_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Depth 0: zero-latency pass-through
    step(3'd0, 1'b1, 8'h01);
    step(3'd0, 1'b1, 8'h02);

    // Latency 3 after the flush completes
    step(3'd3, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(3'd3, 1'b0, 8'h00);
    step(3'd3, 1'b1, 8'hA1);
    step(3'd3, 1'b1, 8'hA2);
    step(3'd3, 1'b1, 8'hA3);
    for (int i = 0; i < 4; i++) step(3'd3, 1'b0, 8'h00);

    // Streaming at depth 2, then switch to 4: in-flight words are dropped
    step(3'd2, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) step(3'd2, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step(3'd2, 1'b1, 8'hB0 + 8'(i));
    step(3'd4, 1'b1, 8'hC0);
    for (int i = 1; i <= 6; i++) step(3'd4, 1'b1, 8'hC0 + 8'(i));
    for (int i = 0; i < 5; i++) step(3'd4, 1'b0, 8'h00);

    // Clamp: 7 behaves as 4, and 7 -> 4 is not a change
    step(3'd1, 1'b0, 8'h00);
    step(3'd1, 1'b0, 8'h00);
    step(3'd7, 1'b0, 8'h00);
    for (int i = 1; i <= 4; i++) step(3'd7, 1'b1, 8'hD0 + 8'(i));
    step(3'd4, 1'b1, 8'hD5);
    step(3'd4, 1'b1, 8'hD6);
    for (int i = 0; i < 5; i++) step(3'd4, 1'b0, 8'h00);

    // Mid-flush change 0 -> 4 -> 2 restarts the flush
    step(3'd0, 1'b0, 8'h00);
    step(3'd4, 1'b0, 8'h00);
    step(3'd4, 1'b0, 8'h00);
    step(3'd2, 1'b0, 8'h00);
    for (int i = 1; i <= 3; i++) step(3'd2, 1'b1, 8'hE0 + 8'(i));
    for (int i = 0; i < 3; i++) step(3'd2, 1'b0, 8'h00);

    // Reset pulse mid-flush, then a normal flush from depth 0
    step(3'd0, 1'b0, 8'h00);
    step(3'd4, 1'b1, 8'h11);
    step(3'd4, 1'b1, 8'h12);
    pulse_reset();
    step(3'd0, 1'b0, 8'h00);
    step(3'd4, 1'b0, 8'h00);
    step(3'd4, 1'b1, 8'hF1);
    step(3'd4, 1'b1, 8'hF2);
    for (int i = 0; i < 5; i++) step(3'd4, 1'b0, 8'h00);

    // Hold behaviour at depth 1 and at depth 0
    step(3'd1, 1'b0, 8'h00);
    step(3'd1, 1'b0, 8'h00);
    step(3'd1, 1'b1, 8'h5C);
    step(3'd1, 1'b0, 8'hFF);
    step(3'd1, 1'b0, 8'hFF);
`ifdef BUF_PIPE_HOLD_EN
    check("hold_d1", dout, 8'h5C);
`else
    check("raw_d1", dout, 8'hFF);
`endif
    step(3'd0, 1'b0, 8'h00);
    step(3'd0, 1'b0, 8'h33);
`ifdef BUF_PIPE_HOLD_EN
    check("hold_d0", dout, 8'h5C);
`else
    check("raw_d0", dout, 8'h33);
`endif

    check("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
